uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver with configurable oversampling ratio, data width, parity mode and stop-bit count. It adds a two-flop input synchroniser, 3-sample majority voting, false-start rejection, a valid/ready output handshake, overrun detection and break detection. It sits between the board RX pin and the byte-stream consumer (FIFO, command parser) in the AX301 UART path, and supersedes the fixed 8-bit, 16x receiver.

## Interface
- OVERSAMPLE, 16: `samp_en` strobes per bit period; legal 8..64, even.
- DATA_BITS, 8: data bits per frame, 5..9, sent LSB first.
- PARITY, 0: parity mode; 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- samp_en  in  1  one-cycle sample strobe at OVERSAMPLE × baud; tie to 1 when clk is the oversample clock.
- rx  in  1  asynchronous serial line; idles high.
- m_data  out  DATA_BITS  received word.
- m_valid  out  1  m_data and its flags are valid.
- m_ready  in  1  consumer accepts the word when m_valid && m_ready.
- parity_err  out  1  parity mismatch for the held word; always 0 when PARITY=0.
- frame_err  out  1  a stop bit sampled 0 for the held word.
- overrun  out  1  sticky: a completed frame was dropped.
- err_clr  in  1  one-cycle pulse that clears overrun.
- break_det  out  1  one-cycle pulse on a break frame.
- busy  out  1  a frame is in progress (FSM not in IDLE).

## Operation
- Synchroniser: two flops, `rx_s`. Both flops reset to 1.
- All FSM and counter activity advances only on cycles with samp_en=1.
- `scnt` (width $clog2(OVERSAMPLE)) counts 0..OVERSAMPLE-1 within each bit. MID = OVERSAMPLE/2.
- Bit value: majority of `rx_s` at scnt = MID-1, MID and MID+1. The decision is taken at scnt = MID+1.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: a tick with previous rx_s=1 and current rx_s=0 moves to START with scnt=0.
  - START: a majority of 1 is a false start; return to IDLE with no flags and no output. A majority of 0 stays in START until scnt = OVERSAMPLE-1, then moves to DATA.
  - DATA: shift in DATA_BITS bits LSB first. Bit counter width is $clog2(DATA_BITS+1). After the last bit, go to PARITY if PARITY≠0, else STOP.
  - PARITY: expected bit is ^data for even, ~^data for odd. A mismatch sets the frame's parity error.
  - STOP: sample STOP_BITS bits; any 0 sets the frame's frame error. At the decision of the last stop bit (scnt = MID+1) the frame completes and the FSM returns to IDLE immediately, without waiting out the rest of the bit. This tolerates up to half a bit of baud mismatch.
- Frame completion:
  - m_valid=0, or m_valid && m_ready in the same cycle: load m_data, parity_err and frame_err; m_valid=1. No overrun in the simultaneous case.
  - m_valid=1 && !m_ready: discard the new frame, keep the old word and flags, set overrun=1.
- Handshake: m_valid && m_ready with no completion clears m_valid. m_data and the flags hold their last values.
- Overrun: set by a drop, cleared only by err_clr or reset. A drop in the same cycle as err_clr leaves overrun=1.
- Break: data all 0, parity bit 0 (if present) and stop sample 0. The frame is delivered as above with frame_err=1, and break_det pulses for 1 cycle even if the word is dropped. A new frame needs rx_s to return high first, because IDLE waits for a falling edge.
- Reset, including mid-frame: FSM to IDLE, counters 0, m_data=0, m_valid=0, parity_err=0, frame_err=0, overrun=0, break_det=0, busy=0.

## Timing
- rx pin to rx_s: 2 clk cycles.
- Completion tick, counted from the detection tick: N·OVERSAMPLE + MID + 1, where N = DATA_BITS + (PARITY≠0) + STOP_BITS. Example: 8N1 at 16x gives 9·16 + 9 = 153 ticks.
- m_valid, the flags and break_det are registered; they are visible in the cycle after the completion tick.
- busy rises in the cycle after the detection tick and falls in the cycle after completion or false-start rejection.
- m_ready is combinationally unused; no path exists from m_ready to any output in the same cycle.

## Test plan
- 8N1, 16x, samp_en=1, m_ready=1, send 0xA5 → m_data=0xA5, m_valid high for 1 cycle, 153 ticks after detection plus 2 sync cycles; all flags 0.
- PARITY=1, send 0x37 with parity bit 0 (correct bit is 1) → m_data=0x37, parity_err=1, frame_err=0. Repeat with PARITY=2 and parity bit 0 → parity_err=0.
- rx low for 4 ticks, then high → busy pulses, then 0; no m_valid. The next valid frame 0x5A is received correctly.
- m_ready=0, send 0x11 then 0x22 → m_data=0x11, overrun=1. Raise m_ready → 0x11 is consumed and overrun stays 1. err_clr → overrun=0.
- STOP_BITS=2, send 0x3C with second stop bit 0 → frame_err=1. Line low for 12 bit times → m_data=0x00, frame_err=1, break_det pulses once; no second frame until rx returns high.
- Assert rst_n=0 in the middle of data bit 4 → all outputs 0 asynchronously. Release and send 0xC3 → received correctly with no flags.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised oversampling UART receiver.
//
// Receives asynchronous serial frames (start, DATA_BITS data LSB first,
// optional parity, STOP_BITS stop bits) and presents each word on a
// valid/ready output. The line is synchronised by two flops. Each bit is
// the 3-sample majority around mid-bit. False starts, overruns and break
// frames are detected.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   samp_en    oversample strobe (OVERSAMPLE per bit period)
//   rx         serial line, idles high
//   m_data     received word
//   m_valid    m_data and flags valid
//   m_ready    consumer accepts the word when m_valid && m_ready
//   parity_err parity mismatch of the held word
//   frame_err  a stop bit sampled 0 for the held word
//   overrun    sticky: a completed frame was dropped
//   err_clr    clears overrun
//   break_det  one-cycle pulse on a break frame
//   busy       frame in progress
module uart_rx_param #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 samp_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 break_det,
    output logic                 busy
);

    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int MID = OVERSAMPLE / 2;

    localparam logic [SW-1:0] SC_MID_M1 = SW'(MID - 1);
    localparam logic [SW-1:0] SC_MID    = SW'(MID);
    localparam logic [SW-1:0] SC_MID_P1 = SW'(MID + 1);
    localparam logic [SW-1:0] SC_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BC_DATA   = BW'(DATA_BITS);
    localparam logic [BW-1:0] BC_STOP_L = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic                   r_rx_prev;
    logic [SW-1:0]          r_scnt;
    logic [BW-1:0]          r_bcnt;
    logic [1:0]             r_samp;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_bit;
    logic                   r_stop_err;
    logic                   r_stop_one;
    logic [DATA_BITS-1:0]   r_m_data;
    logic                   r_m_valid;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_break;

    logic                   w_fall;
    logic                   w_decide;
    logic                   w_bit_end;
    logic                   w_bit;
    logic                   w_complete;
    logic                   w_frame_err;
    logic                   w_par_exp;
    logic                   w_par_err;
    logic                   w_break;

    // Two-flop synchroniser; idles high so reset must not look like a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_fall    = r_rx_prev & ~r_rx_s;
    assign w_decide  = (r_scnt == SC_MID_P1);
    assign w_bit_end = (r_scnt == SC_LAST);
    // Majority of the two stored samples and the sample taken now.
    assign w_bit     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s) | (r_samp[1] & r_rx_s);

    // State register: advances only on oversample ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (samp_en) begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic (evaluated as if this cycle were a tick).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_state_next = S_START;
            S_START: begin
                if (w_decide && w_bit)  w_state_next = S_IDLE;
                else if (w_bit_end)     w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && (r_bcnt == BC_DATA))
                    w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_bit_end) w_state_next = S_STOP;
            // Leave at the last stop decision, not at the end of the bit,
            // so a fast transmitter's next start edge is not missed.
            S_STOP:   if (w_decide && (r_bcnt == BC_STOP_L)) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output / frame-result decode.
    always_comb begin
        w_complete  = samp_en && (r_state == S_STOP) && w_decide && (r_bcnt == BC_STOP_L);
        w_frame_err = r_stop_err | ~w_bit;
        w_par_exp   = (PARITY == 2) ? ~^r_shift : ^r_shift;
        w_par_err   = (PARITY != 0) && (r_par_bit != w_par_exp);
        w_break     = (r_shift == '0) && ((PARITY == 0) || !r_par_bit) && !(r_stop_one | w_bit);
        busy        = (r_state != S_IDLE);
    end

    // Bit timing, sampling and frame assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_prev  <= 1'b1;
            r_scnt     <= '0;
            r_bcnt     <= '0;
            r_samp     <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_stop_err <= 1'b0;
            r_stop_one <= 1'b0;
        end else if (samp_en) begin
            r_rx_prev <= r_rx_s;

            // The detection tick is position 0 of the start bit.
            if (r_state == S_IDLE)
                r_scnt <= w_fall ? SW'(1) : '0;
            else if ((w_state_next == S_IDLE) || w_bit_end)
                r_scnt <= '0;
            else
                r_scnt <= r_scnt + 1'b1;

            if (r_scnt == SC_MID_M1) r_samp[0] <= r_rx_s;
            if (r_scnt == SC_MID)    r_samp[1] <= r_rx_s;

            case (r_state)
                S_IDLE: begin
                    r_bcnt     <= '0;
                    r_stop_err <= 1'b0;
                    r_stop_one <= 1'b0;
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bcnt  <= r_bcnt + 1'b1;
                    end else if (w_bit_end && (r_bcnt == BC_DATA)) begin
                        r_bcnt  <= '0;   // reused as stop-bit counter
                    end
                end
                S_PARITY: if (w_decide) r_par_bit <= w_bit;
                S_STOP: begin
                    if (w_decide) begin
                        r_bcnt     <= r_bcnt + 1'b1;
                        r_stop_err <= r_stop_err | ~w_bit;
                        r_stop_one <= r_stop_one | w_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output word register and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_break      <= 1'b0;
        end else begin
            r_break <= w_complete && w_break;

            if (w_complete && (!r_m_valid || m_ready)) begin
                r_m_data     <= r_shift;
                r_parity_err <= w_par_err;
                r_frame_err  <= w_frame_err;
                r_m_valid    <= 1'b1;
            end else if (r_m_valid && m_ready) begin
                r_m_valid    <= 1'b0;
            end

            // A drop wins over a simultaneous clear.
            if (w_complete && r_m_valid && !m_ready)
                r_overrun <= 1'b1;
            else if (err_clr)
                r_overrun <= 1'b0;
        end
    end

    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign break_det  = r_break;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- self-checking bench for uart_rx_param.
// Four receivers with different configurations:
//   u0: 8N1 16x, u1: 8E1 16x, u2: 8O1 16x (all samp_en=1),
//   u3: 7N2 8x with samp_en every other clock (16 clocks per bit).
module tb_uart_rx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic se_full = 1'b1;
    logic se_half = 1'b0;

    logic rx0, rx1, rx2, rx3;
    logic rdy0, rdy1, rdy2, rdy3;
    logic clr0, clr1, clr2, clr3;
    logic [7:0] d0, d1, d2;
    logic [6:0] d3;
    logic v0, v1, v2, v3, pe0, pe1, pe2, pe3, fe0, fe1, fe2, fe3;
    logic ov0, ov1, ov2, ov3, brk0, brk1, brk2, brk3, bsy0, bsy1, bsy2, bsy3;

    uart_rx_param #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .samp_en(se_full), .rx(rx0), .m_data(d0), .m_valid(v0),
        .m_ready(rdy0), .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .err_clr(clr0),
        .break_det(brk0), .busy(bsy0));
    uart_rx_param #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .samp_en(se_full), .rx(rx1), .m_data(d1), .m_valid(v1),
        .m_ready(rdy1), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .err_clr(clr1),
        .break_det(brk1), .busy(bsy1));
    uart_rx_param #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .samp_en(se_full), .rx(rx2), .m_data(d2), .m_valid(v2),
        .m_ready(rdy2), .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .err_clr(clr2),
        .break_det(brk2), .busy(bsy2));
    uart_rx_param #(.OVERSAMPLE(8), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .samp_en(se_half), .rx(rx3), .m_data(d3), .m_valid(v3),
        .m_ready(rdy3), .parity_err(pe3), .frame_err(fe3), .overrun(ov3), .err_clr(clr3),
        .break_det(brk3), .busy(bsy3));

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } item_t;

    item_t q0[$], q1[$], q2[$], q3[$];
    int    cyc = 0;
    int    brk_cnt[4] = '{default: 0};
    int    vh_cnt[4]  = '{default: 0};
    int    vr_cnt[4]  = '{default: 0};
    int    t_vr[4]    = '{default: 0};
    logic  vq[4]      = '{default: 1'b0};
    int    t_start[4] = '{default: 0};
    int    n_cmp = 0;
    int    n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1 se_half = ~se_half;
        end
    end

    // Output monitor: every accepted word goes to a per-receiver queue.
    always @(negedge clk) begin
        if (v0 && rdy0) q0.push_back({1'b0, d0, pe0, fe0});
        if (v1 && rdy1) q1.push_back({1'b0, d1, pe1, fe1});
        if (v2 && rdy2) q2.push_back({1'b0, d2, pe2, fe2});
        if (v3 && rdy3) q3.push_back({2'b00, d3, pe3, fe3});
        if (brk0) brk_cnt[0] <= brk_cnt[0] + 1;
        if (brk1) brk_cnt[1] <= brk_cnt[1] + 1;
        if (brk2) brk_cnt[2] <= brk_cnt[2] + 1;
        if (brk3) brk_cnt[3] <= brk_cnt[3] + 1;
        if (v0) vh_cnt[0] <= vh_cnt[0] + 1;
        if (v0 && !vq[0]) begin
            vr_cnt[0] <= vr_cnt[0] + 1;
            t_vr[0]   <= cyc;
        end
        vq[0] <= v0;
    end

    // Reference model: expected word/flags from the frame as sent.
    function automatic item_t model_item(input int pmode, input logic [8:0] data,
                                         input logic pbit, input int nstop,
                                         input logic [1:0] stops);
        item_t e;
        int    ones;
        ones = $countones(data) + int'(pbit);
        e.d  = data;
        if (pmode == 1)      e.pe = (ones % 2) == 1;
        else if (pmode == 2) e.pe = (ones % 2) == 0;
        else                 e.pe = 1'b0;
        e.fe = (stops[0] == 1'b0) || ((nstop == 2) && (stops[1] == 1'b0));
        return e;
    endfunction

    function automatic int model_brk(input int pmode, input logic [8:0] data,
                                     input logic pbit, input int nstop,
                                     input logic [1:0] stops);
        int all_low;
        all_low = (stops[0] == 1'b0) && ((nstop == 1) || (stops[1] == 1'b0));
        return ((data == 0) && ((pmode == 0) || !pbit) && (all_low != 0)) ? 1 : 0;
    endfunction

    task automatic set_rx(input int idx, input logic v);
        case (idx)
            0: rx0 = v;
            1: rx1 = v;
            2: rx2 = v;
            default: rx3 = v;
        endcase
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input int idx, input logic v, input int n);
        set_rx(idx, v);
        wait_cyc(n);
    endtask

    task automatic send_frame(input int idx, input int cpb, input int nbits,
                              input logic [8:0] data, input int npar, input logic pbit,
                              input int nstop, input logic [1:0] stops);
        t_start[idx] = cyc;
        hold(idx, 1'b0, cpb);
        for (int i = 0; i < nbits; i++) hold(idx, data[i], cpb);
        if (npar != 0) hold(idx, pbit, cpb);
        for (int s = 0; s < nstop; s++) hold(idx, stops[s], cpb);
        set_rx(idx, 1'b1);
    endtask

    task automatic pop_item(input int idx, output item_t it, output bit ok);
        ok = 1'b0;
        it = '0;
        case (idx)
            0: if (q0.size() > 0) begin it = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin it = q1.pop_front(); ok = 1'b1; end
            2: if (q2.size() > 0) begin it = q2.pop_front(); ok = 1'b1; end
            default: if (q3.size() > 0) begin it = q3.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {rx0, rx1, rx2, rx3}     = 4'hF;
        {rdy0, rdy1, rdy2, rdy3} = 4'hF;
        {clr0, clr1, clr2, clr3} = 4'h0;
        wait_cyc(4);
        n_cmp++; if ({d0, v0, pe0, fe0, ov0, brk0, bsy0} !== '0) begin
            $display("FAIL reset_u0: got %h required 0", {d0, v0, pe0, fe0, ov0, brk0, bsy0}); n_fail++; end
        n_cmp++; if ({d1, v1, pe1, fe1, ov1, brk1, bsy1} !== '0) begin
            $display("FAIL reset_u1: got %h required 0", {d1, v1, pe1, fe1, ov1, brk1, bsy1}); n_fail++; end
        n_cmp++; if ({d2, v2, pe2, fe2, ov2, brk2, bsy2} !== '0) begin
            $display("FAIL reset_u2: got %h required 0", {d2, v2, pe2, fe2, ov2, brk2, bsy2}); n_fail++; end
        n_cmp++; if ({d3, v3, pe3, fe3, ov3, brk3, bsy3} !== '0) begin
            $display("FAIL reset_u3: got %h required 0", {d3, v3, pe3, fe3, ov3, brk3, bsy3}); n_fail++; end
        rst_n = 1'b1;
        wait_cyc(8);
    endtask

    task automatic test_basic();
        item_t it, exp_it;
        bit    ok;
        int    vh0, vr0, b0;
        vh0 = vh_cnt[0]; vr0 = vr_cnt[0]; b0 = brk_cnt[0];
        send_frame(0, 16, 8, 9'h0A5, 0, 1'b0, 1, 2'b11);
        wait_cyc(16);
        exp_it = model_item(0, 9'h0A5, 1'b0, 1, 2'b11);
        pop_item(0, it, ok);
        n_cmp++; if (!ok || it !== exp_it) begin
            $display("FAIL basic_word: got %h (present=%0d) required %h", it, ok, exp_it); n_fail++; end
        // 2 sync edges + detection edge, then 9*16+9 ticks to completion.
        n_cmp++; if (t_vr[0] - t_start[0] !== 3 + 9 * 16 + 9) begin
            $display("FAIL basic_latency: got %0d required %0d", t_vr[0] - t_start[0], 3 + 9 * 16 + 9); n_fail++; end
        n_cmp++; if (vh_cnt[0] - vh0 !== 1 || vr_cnt[0] - vr0 !== 1) begin
            $display("FAIL basic_valid_width: got %0d cycles required 1", vh_cnt[0] - vh0); n_fail++; end
        n_cmp++; if ({v0, ov0, bsy0} !== 3'b000 || brk_cnt[0] !== b0) begin
            $display("FAIL basic_idle_flags: got v/ov/busy=%b brk=%0d required 000 0", {v0, ov0, bsy0}, brk_cnt[0] - b0); n_fail++; end
        $display("basic: sent A5 got %h latency %0d", it, t_vr[0] - t_start[0]);
    endtask

    task automatic test_parity();
        item_t it;
        bit    ok;
        send_frame(1, 16, 8, 9'h037, 1, 1'b0, 1, 2'b11);
        wait_cyc(4);
        pop_item(1, it, ok);
        n_cmp++; if (!ok || it !== {9'h037, 1'b1, 1'b0}) begin
            $display("FAIL parity_even: got %h required %h", it, {9'h037, 1'b1, 1'b0}); n_fail++; end
        $display("parity even: got %h", it);
        send_frame(2, 16, 8, 9'h037, 1, 1'b0, 1, 2'b11);
        wait_cyc(4);
        pop_item(2, it, ok);
        n_cmp++; if (!ok || it !== {9'h037, 1'b0, 1'b0}) begin
            $display("FAIL parity_odd: got %h required %h", it, {9'h037, 1'b0, 1'b0}); n_fail++; end
        $display("parity odd: got %h", it);
    endtask

    task automatic test_false_start();
        item_t it;
        bit    ok;
        int    vr0;
        vr0 = vr_cnt[0];
        hold(0, 1'b0, 4);
        n_cmp++; if (bsy0 !== 1'b1) begin
            $display("FAIL false_start_busy_high: got %b required 1", bsy0); n_fail++; end
        hold(0, 1'b1, 20);
        n_cmp++; if (bsy0 !== 1'b0 || vr_cnt[0] !== vr0 || q0.size() !== 0) begin
            $display("FAIL false_start_reject: got busy=%b words=%0d required 0 0", bsy0, vr_cnt[0] - vr0); n_fail++; end
        send_frame(0, 16, 8, 9'h05A, 0, 1'b0, 1, 2'b11);
        wait_cyc(4);
        pop_item(0, it, ok);
        n_cmp++; if (!ok || it !== {9'h05A, 2'b00}) begin
            $display("FAIL false_start_next: got %h required %h", it, {9'h05A, 2'b00}); n_fail++; end
        $display("false start then 5A: got %h", it);
    endtask

    task automatic test_overrun();
        item_t it;
        bit    ok;
        rdy0 = 1'b0;
        send_frame(0, 16, 8, 9'h011, 0, 1'b0, 1, 2'b11);
        wait_cyc(4);
        send_frame(0, 16, 8, 9'h022, 0, 1'b0, 1, 2'b11);
        wait_cyc(4);
        n_cmp++; if ({v0, d0, ov0} !== {1'b1, 8'h11, 1'b1}) begin
            $display("FAIL overrun_hold: got v=%b d=%h ov=%b required 1 11 1", v0, d0, ov0); n_fail++; end
        rdy0 = 1'b1;
        wait_cyc(2);
        pop_item(0, it, ok);
        n_cmp++; if (!ok || it !== {9'h011, 2'b00} || q0.size() !== 0) begin
            $display("FAIL overrun_consume: got %h required %h", it, {9'h011, 2'b00}); n_fail++; end
        n_cmp++; if ({v0, ov0} !== 2'b01) begin
            $display("FAIL overrun_sticky: got v/ov=%b required 01", {v0, ov0}); n_fail++; end
        clr0 = 1'b1;
        wait_cyc(1);
        clr0 = 1'b0;
        n_cmp++; if (ov0 !== 1'b0) begin
            $display("FAIL overrun_clear: got %b required 0", ov0); n_fail++; end
        $display("overrun: kept %h, overrun cleared to %b", it, ov0);
    endtask

    task automatic test_stop_break();
        item_t it, exp_it;
        bit    ok;
        int    b3;
        b3 = brk_cnt[3];
        send_frame(3, 16, 7, 9'h03C, 0, 1'b0, 2, 2'b01);
        wait_cyc(4);
        exp_it = model_item(0, 9'h03C, 1'b0, 2, 2'b01);
        pop_item(3, it, ok);
        n_cmp++; if (!ok || it !== exp_it || brk_cnt[3] !== b3) begin
            $display("FAIL stop2_frame_err: got %h brk=%0d required %h 0", it, brk_cnt[3] - b3, exp_it); n_fail++; end
        $display("stop2 bad second stop: got %h", it);
        hold(3, 1'b0, 12 * 16);
        exp_it = model_item(0, 9'h000, 1'b0, 2, 2'b00);
        pop_item(3, it, ok);
        n_cmp++; if (!ok || it !== exp_it) begin
            $display("FAIL break_word: got %h required %h", it, exp_it); n_fail++; end
        n_cmp++; if (brk_cnt[3] - b3 !== model_brk(0, 9'h000, 1'b0, 2, 2'b00)) begin
            $display("FAIL break_pulse: got %0d pulses required 1", brk_cnt[3] - b3); n_fail++; end
        hold(3, 1'b0, 64);
        n_cmp++; if (q3.size() !== 0 || brk_cnt[3] - b3 !== 1 || v3 !== 1'b0) begin
            $display("FAIL break_no_second: got words=%0d pulses=%0d required 0 1", q3.size(), brk_cnt[3] - b3); n_fail++; end
        hold(3, 1'b1, 32);
        send_frame(3, 16, 7, 9'h02B, 0, 1'b0, 2, 2'b11);
        wait_cyc(4);
        pop_item(3, it, ok);
        n_cmp++; if (!ok || it !== {9'h02B, 2'b00}) begin
            $display("FAIL break_recover: got %h required %h", it, {9'h02B, 2'b00}); n_fail++; end
        $display("break then 2B: got %h", it);
    endtask

    task automatic test_random();
        item_t        it, exp_it;
        bit           ok;
        int           idx, b, exp_b, gap;
        logic [8:0]   data;
        logic         pbit;
        logic [1:0]   stops;
        for (int k = 0; k < 24; k++) begin
            idx   = $urandom_range(0, 2);
            data  = 9'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) data = 9'h000;
            pbit  = 1'($urandom_range(0, 1));
            stops = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b11;
            b     = brk_cnt[idx];
            send_frame(idx, 16, 8, data, (idx != 0) ? 1 : 0, pbit, 1, stops);
            wait_cyc(1);
            exp_it = model_item(idx, data, pbit, 1, stops);
            exp_b  = model_brk(idx, data, pbit, 1, stops);
            pop_item(idx, it, ok);
            n_cmp++; if (!ok || it !== exp_it || brk_cnt[idx] - b !== exp_b) begin
                $display("FAIL random_%0d_u%0d: got %h brk=%0d required %h brk=%0d",
                         k, idx, it, brk_cnt[idx] - b, exp_it, exp_b); n_fail++; end
            $display("random %0d u%0d: sent %h par=%b stop=%b got %h", k, idx, data, pbit, stops[0], it);
            // Zero gap means back-to-back frames; a low stop needs the line high again first.
            gap = stops[0] ? $urandom_range(0, 4) : 16;
            if (gap > 0) hold(idx, 1'b1, gap);
        end
    endtask

    task automatic test_reset_mid();
        item_t      it;
        bit         ok;
        logic [8:0] data;
        data = 9'h0C3;
        hold(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) hold(0, data[i], 16);
        hold(0, data[4], 8);
        n_cmp++; if (bsy0 !== 1'b1) begin
            $display("FAIL reset_mid_busy: got %b required 1", bsy0); n_fail++; end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({d0, v0, pe0, fe0, ov0, brk0, bsy0} !== '0) begin
            $display("FAIL reset_mid_async: got %h required 0", {d0, v0, pe0, fe0, ov0, brk0, bsy0}); n_fail++; end
        set_rx(0, 1'b1);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(32);
        send_frame(0, 16, 8, data, 0, 1'b0, 1, 2'b11);
        wait_cyc(4);
        pop_item(0, it, ok);
        n_cmp++; if (!ok || it !== {9'h0C3, 2'b00} || ov0 !== 1'b0) begin
            $display("FAIL reset_mid_recover: got %h ov=%b required %h 0", it, ov0, {9'h0C3, 2'b00}); n_fail++; end
        $display("reset mid-frame then C3: got %h", it);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_overrun();
        test_stop_break();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
